risc_mc_core: RTL
=================

// Module: risc_mc_core
// PURPOSE
//  Parametrised multi-cycle RISC-V subset core with byte-serial program load port.
//  Each instruction steps through a state machine; no pipeline, no hazard logic.
//  Successor to the fixed 32-bit pipelined core: configurable data width, register
//  count and memory depths, plus run/halt control. Sits at the tile top level.
// PARAMETERS
//  XLEN       32  datapath/register width (16..32); immediates truncated to XLEN
//  NREGS      32  architectural registers (16 or 32); x0 reads 0
//  IMEM_AW    5   instruction memory word-address bits (depth 2**IMEM_AW words)
//  DMEM_AW    5   data memory word-address bits
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  run            in   1        level; 1 = execute, 0 = go/stay IDLE
//  inst_we        in   1        program-load byte write strobe
//  inst_address   in   IMEM_AW+2  byte address; word = addr[IMEM_AW+1:2], lane = addr[1:0]
//  inst_data      in   8        program byte, little-endian within word
//  pc_out         out  IMEM_AW  current PC (word index)
//  halted         out  1        1 in HALT state
//  memory_out     out  8        low byte of last store data written to data memory
//  retired_count  out  32       retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pc_out=0, halted=0, memory_out=0, retired_count=0, regs=0.
//   Memories not cleared.
//  Memories: synchronous read, one-cycle latency; word addressed.
//  Load port: inst_we writes one byte at any time, any state; fetch of a word
//   written in the same cycle returns the old word.
//  States: IDLE -> FETCH when run=1 (PC unchanged). FETCH: present PC to imem.
//   DECODE: latch instruction, read rs1/rs2. EXEC: ALU / branch compare.
//   MEM: load/store access. WB: register write. HALT: terminal.
//  Paths / cycles per instruction:
//   R-type, ADDI, JAL:  FETCH,DECODE,EXEC,WB = 4
//   LW: FETCH,DECODE,EXEC,MEM,WB = 5;  SW: FETCH,DECODE,EXEC,MEM = 4
//   BEQ/BNE: FETCH,DECODE,EXEC = 3;  ECALL (0x00000073): FETCH,DECODE -> HALT
//  ISA: ADD SUB AND OR XOR SLT SLTU, ADDI, LW SW, BEQ BNE, JAL, ECALL.
//   Any other encoding = NOP: DECODE -> FETCH, PC+1, counts as retired.
//  PC: +1 per instruction, modulo 2**IMEM_AW. Branch/JAL target =
//   PC + (imm >>> 2), wrapping. JAL writes PC+1 (zero-extended) to rd.
//  Data address = ALU result[DMEM_AW-1:0]; upper bits ignored (wrap).
//  Arithmetic mod 2**XLEN; SLT signed, SLTU unsigned; imm sign-extended to XLEN.
//  Register index >= NREGS: reads 0, writes dropped. Writes to x0 dropped.
//  run=0 sampled only in FETCH: return to IDLE, PC held; in-flight instr completes.
//  HALT: PC frozen at ECALL address; leave only via reset.
//  Async reset mid-instruction: state, PC and outputs return to reset values.
//  memory_out updates in the cycle after the SW MEM state.
// CONFIGURATION
//  RISC_MC_RETIRE_CNT_EN defined: retired_count increments by 1 at each instruction
//   completion (WB, SW MEM, branch EXEC, NOP DECODE); wraps at 2**32; ECALL not counted.
//  Undefined: retired_count tied to 0; no counter flops.
// TESTING
//  Load ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SW x3,0(x0); ECALL; run=1
//   -> memory_out=0x0C, halted=1, pc_out=4.
//  SW x3 to addr 3 then LW x4,3(x0); SW x4,1(x0) -> memory_out=0x0C.
//   LW takes exactly 5 cycles FETCH->FETCH.
//  BEQ x1,x1,+8 at PC 2 -> next fetch at PC 4. BNE x1,x1 -> PC 3; each 3 cycles.
//  JAL x5,-8 at PC 6 -> PC 4, x5=7. Branch at last word with +4 wraps to PC 0.
//  Assert rst_n low during EXEC of ADD x3 -> all outputs reset immediately,
//   x3 unchanged; drop run mid-program -> IDLE at next FETCH, PC held, resume on run=1.
//  With RISC_MC_RETIRE_CNT_EN: first program -> retired_count=4;
//   without macro -> retired_count=0 throughout.

Source files
------------

// File: rtl/risc_mc_core.sv
// Purpose : multi-cycle RISC-V subset core (ADD SUB AND OR XOR SLT SLTU ADDI LW SW BEQ BNE JAL ECALL)
//           with a byte-serial program load port and run/halt control.
// Latency : 3 cycles (branches), 4 (R-type/ADDI/JAL/SW), 5 (LW), 2 (unsupported encoding = NOP).
//           ECALL halts after DECODE.
// Backpr. : run is a level. It is sampled only in FETCH; a low level parks the core in IDLE
//           with the PC held. An instruction that is already in flight always completes.
// Ports   : clk/rst_n (async active-low); run; inst_we/inst_address/inst_data byte-wide
//           program load; pc_out (word index); halted; memory_out (low byte of last store);
//           retired_count (retired instructions).
// Config  : RISC_MC_RETIRE_CNT_EN enables the retired-instruction counter. When it is
//           undefined, retired_count is tied to 0.
module risc_mc_core #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int IMEM_AW = 5,
  parameter int DMEM_AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               inst_we,
  input  logic [IMEM_AW+1:0] inst_address,
  input  logic [7:0]         inst_data,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               halted,
  output logic [7:0]         memory_out,
  output logic [31:0]        retired_count
);

  localparam int                 RIW     = $clog2(NREGS);
  localparam logic [5:0]         NREGS_L = 6'(NREGS);
  localparam logic [IMEM_AW-1:0] PC_ONE  = IMEM_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
    OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_ECALL
  } op_t;

  state_t             state;
  op_t                op;
  op_t                dec_op;
  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] pc_inc;
  logic [IMEM_AW-1:0] br_tgt;
  logic [IMEM_AW-1:0] jal_tgt;
  // Only the bits needed after DECODE are kept: rd, the immediate fields and the JAL offset.
  logic [31:7]        ir;
  logic [4:0]         rd_idx;
  logic [31:0]        imem [2**IMEM_AW];
  logic [31:0]        imem_rdata;
  logic [XLEN-1:0]    dmem [2**DMEM_AW];
  logic [XLEN-1:0]    dmem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [XLEN-1:0]    regs [NREGS];
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    alu_out;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    imm_s;
  logic               br_taken;

  assign pc_out    = pc;
  assign pc_inc    = pc + PC_ONE;
  assign rd_idx    = ir[11:7];
  assign dmem_addr = alu_res[DMEM_AW-1:0];

  // The immediates are sign-extended to 32 bits and then truncated to XLEN.
  // Branch and JAL offsets are built directly as imm >>> 2, because the PC counts words.
  assign imm_i   = XLEN'({{20{ir[31]}}, ir[31:20]});
  assign imm_s   = XLEN'({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign br_tgt  = pc + IMEM_AW'({{21{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:9]});
  assign jal_tgt = pc + IMEM_AW'({{13{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:22]});

  // Instruction memory: byte-lane writes from the load port, and a synchronous word read at
  // the PC. A word written in the same cycle as the fetch reads back its old value.
  always_ff @(posedge clk) begin
    if (inst_we)
      imem[inst_address[IMEM_AW+1:2]][{inst_address[1:0], 3'b000} +: 8] <= inst_data;
    imem_rdata <= imem[pc];
  end

  // Data memory: the address comes from the ALU result registered in EXEC.
  always_ff @(posedge clk) begin
    if (state == S_MEM && op == OP_SW)
      dmem[dmem_addr] <= rs2_val;
    dmem_rdata <= dmem[dmem_addr];
  end

  function automatic logic [XLEN-1:0] reg_rd(input logic [4:0] idx);
    if ({1'b0, idx} < NREGS_L)
      return regs[idx[RIW-1:0]];
    return '0;
  endfunction

  always_comb begin
    dec_op = OP_NOP;
    case (imem_rdata[6:0])
      7'b0110011: begin
        if (imem_rdata[31:25] == 7'h00) begin
          case (imem_rdata[14:12])
            3'd0:    dec_op = OP_ADD;
            3'd2:    dec_op = OP_SLT;
            3'd3:    dec_op = OP_SLTU;
            3'd4:    dec_op = OP_XOR;
            3'd6:    dec_op = OP_OR;
            3'd7:    dec_op = OP_AND;
            default: dec_op = OP_NOP;
          endcase
        end else if (imem_rdata[31:25] == 7'h20 && imem_rdata[14:12] == 3'd0) begin
          dec_op = OP_SUB;
        end
      end
      7'b0010011: if (imem_rdata[14:12] == 3'd0) dec_op = OP_ADDI;
      7'b0000011: if (imem_rdata[14:12] == 3'd2) dec_op = OP_LW;
      7'b0100011: if (imem_rdata[14:12] == 3'd2) dec_op = OP_SW;
      7'b1100011: begin
        if (imem_rdata[14:12] == 3'd0)      dec_op = OP_BEQ;
        else if (imem_rdata[14:12] == 3'd1) dec_op = OP_BNE;
      end
      7'b1101111: dec_op = OP_JAL;
      default:    dec_op = OP_NOP;
    endcase
    if (imem_rdata == 32'h0000_0073)
      dec_op = OP_ECALL;
  end

  always_comb begin
    alu_out = '0;
    case (op)
      OP_ADD:          alu_out = rs1_val + rs2_val;
      OP_SUB:          alu_out = rs1_val - rs2_val;
      OP_AND:          alu_out = rs1_val & rs2_val;
      OP_OR:           alu_out = rs1_val | rs2_val;
      OP_XOR:          alu_out = rs1_val ^ rs2_val;
      OP_SLT:          alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
      OP_SLTU:         alu_out = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
      OP_ADDI, OP_LW:  alu_out = rs1_val + imm_i;
      OP_SW:           alu_out = rs1_val + imm_s;
      OP_JAL:          alu_out = XLEN'(pc_inc);
      default:         alu_out = '0;
    endcase
  end

  assign br_taken = (op == OP_BEQ) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      halted     <= 1'b0;
      memory_out <= '0;
      ir         <= '0;
      op         <= OP_NOP;
      rs1_val    <= '0;
      rs2_val    <= '0;
      alu_res    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE:  if (run) state <= S_FETCH;
        S_FETCH: state <= run ? S_DECODE : S_IDLE;
        S_DECODE: begin
          ir      <= imem_rdata[31:7];
          op      <= dec_op;
          rs1_val <= reg_rd(imem_rdata[19:15]);
          rs2_val <= reg_rd(imem_rdata[24:20]);
          if (dec_op == OP_ECALL) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (dec_op == OP_NOP) begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_res <= alu_out;
          case (op)
            OP_BEQ, OP_BNE: begin
              pc    <= br_taken ? br_tgt : pc_inc;
              state <= S_FETCH;
            end
            OP_LW, OP_SW: state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (op == OP_SW) begin
            memory_out <= rs2_val[7:0];
            pc         <= pc_inc;
            state      <= S_FETCH;
          end else begin
            state <= S_WB;
          end
        end
        S_WB: begin
          // x0 and indices beyond the register file are silently dropped.
          if (rd_idx != 5'd0 && {1'b0, rd_idx} < NREGS_L)
            regs[rd_idx[RIW-1:0]] <= (op == OP_LW) ? dmem_rdata : alu_res;
          pc    <= (op == OP_JAL) ? jal_tgt : pc_inc;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RISC_MC_RETIRE_CNT_EN
  // Completion points: the NOP in DECODE, a branch in EXEC, SW in MEM, and every WB.
  // ECALL is not counted.
  logic retire;
  assign retire = (state == S_DECODE && dec_op == OP_NOP) ||
                  (state == S_EXEC && (op == OP_BEQ || op == OP_BNE)) ||
                  (state == S_MEM && op == OP_SW) ||
                  (state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_count <= '0;
    else if (retire) retired_count <= retired_count + 32'd1;
  end
`else
  assign retired_count = '0;
`endif

endmodule
